// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the input debouncer.
// Holds the default parameter values and the counter width helper.
// Optional feature macro used by this block: DEBOUNCE_EDGE_EN.
package debounce_pkg;

  localparam int DEB_WIDTH_DEFAULT      = 8;
  localparam int DEB_TICK_DIV_DEFAULT   = 50_000;
  localparam int DEB_STABLE_CNT_DEFAULT = 4;

  // $clog2 clamped to at least 1 so that small counts still get a real register
  function automatic int cnt_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between the board inputs and the debouncer.
//   raw_in    : raw asynchronous inputs
//   level_out : debounced levels
//   rise_out  : one-cycle 0->1 pulses (zero unless DEBOUNCE_EDGE_EN)
//   fall_out  : one-cycle 1->0 pulses (zero unless DEBOUNCE_EDGE_EN)
//   tick_out  : one-cycle sample strobe
// master = the producer of raw_in, slave = the debouncer.
interface input_debouncer_if
  import debounce_pkg::*;
#(
  parameter int WIDTH = DEB_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic             tick_out;

  modport master (
    output raw_in,
    input  level_out, rise_out, fall_out, tick_out
  );

  modport slave (
    input  raw_in,
    output level_out, rise_out, fall_out, tick_out
  );

endinterface

// File: rtl/input_debouncer_cell.sv
// One debounced bit: two-flop synchroniser, sample counter, level flop and,
// when DEBOUNCE_EDGE_EN is defined, registered rise/fall pulse flops.
//   clk, rst_n : clock and async active-low reset
//   tick       : shared sample strobe from the top-level prescaler
//   raw        : asynchronous input bit
//   level      : debounced level
//   rise, fall : one-cycle pulses coincident with a level change
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int   STABLE_CNT = DEB_STABLE_CNT_DEFAULT,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_w(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick) begin
      // any agreeing sample restarts the run
      if (sync_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= RESET_VAL;
      sync_q  <= RESET_VAL;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // registered alongside level_q so the pulse lines up with the new level
  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Board-input debouncer: shared sample prescaler plus WIDTH independent
// debounce cells.
//   clk, rst_n : system clock, async active-low reset
//   bus        : input_debouncer_if slave (raw_in in; level_out, rise_out,
//                fall_out, tick_out out)
// Define DEBOUNCE_EDGE_EN to build the rise/fall pulse registers; otherwise
// rise_out/fall_out are tied low.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int               WIDTH      = DEB_WIDTH_DEFAULT,
  parameter int               TICK_DIV   = DEB_TICK_DIV_DEFAULT,
  parameter int               STABLE_CNT = DEB_STABLE_CNT_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input_debouncer_if.slave  bus
);

  localparam int            PW       = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // tick is combinational on the count so wrap and sample share one cycle
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  logic [WIDTH-1:0] level_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .STABLE_CNT (STABLE_CNT),
      .RESET_VAL  (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (bus.raw_in[i]),
      .level (level_v[i]),
      .rise  (rise_v[i]),
      .fall  (fall_v[i])
    );
  end

  assign bus.level_out = level_v;
  assign bus.rise_out  = rise_v;
  assign bus.fall_out  = fall_v;
  assign bus.tick_out  = tick;

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer (TICK_DIV=4, STABLE_CNT=3, WIDTH=8).
// A sliding-window reference model runs every cycle; table vectors and
// hand-written sequences add fixed expectations on top.
module tb_input_debouncer;
  import debounce_pkg::*;

  localparam int TD = 4;
  localparam int SC = 3;
  localparam int W  = 8;
  localparam logic [W-1:0] RV = 8'h00;

`ifdef DEBOUNCE_EDGE_EN
  localparam logic [W-1:0] EDGE_MASK = 8'hFF;
`else
  localparam logic [W-1:0] EDGE_MASK = 8'h00;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  bit   chk_en;

  input_debouncer_if #(.WIDTH(W)) bus ();

  input_debouncer #(
    .WIDTH      (W),
    .TICK_DIV   (TD),
    .STABLE_CNT (SC),
    .RESET_VAL  (RV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // level flips when the last SC tick samples all disagree with it
  logic [W-1:0]  hist0, hist1;
  logic [W-1:0]  m_level, m_rise, m_fall, prev_lvl, sync_v;
  logic [SC-1:0] win [W];
  logic          m_tick;
  int unsigned   m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0   = RV;
      hist1   = RV;
      m_level = RV;
      m_rise  = '0;
      m_fall  = '0;
      m_tick  = 1'b0;
      m_cyc   = 0;
      for (int b = 0; b < W; b++) win[b] = {SC{RV[b]}};
    end else begin
      sync_v   = hist1;
      prev_lvl = m_level;
      if ((m_cyc % TD) == TD - 1) begin
        for (int b = 0; b < W; b++) begin
          win[b] = {win[b][SC-2:0], sync_v[b]};
          if (win[b] == {SC{~prev_lvl[b]}}) m_level[b] = sync_v[b];
        end
      end
      hist1  = hist0;
      hist0  = bus.raw_in;
      m_rise = m_level & ~prev_lvl;
      m_fall = ~m_level & prev_lvl;
      m_cyc++;
      m_tick = ((m_cyc % TD) == TD - 1);
    end
  end

  function automatic int trailing(input int b);
    int n = 0;
    for (int i = 0; i < SC; i++) begin
      if (win[b][i] == m_level[b]) break;
      n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("level", bus.level_out, m_level);
      check("rise",  bus.rise_out,  m_rise & EDGE_MASK);
      check("fall",  bus.fall_out,  m_fall & EDGE_MASK);
      check("tick",  {7'd0, bus.tick_out}, {7'd0, m_tick});
    end
  end

  // ---------------- table vectors ----------------
  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] exp_level;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [W-1:0] r_acc, f_acc;
    int           n;
    int unsigned  rv;

    vecs[0] = '{8'h01, 20, 8'h01, 8'h01, 8'h00};
    vecs[1] = '{8'h03,  6, 8'h01, 8'h00, 8'h00};
    vecs[2] = '{8'h01, 20, 8'h01, 8'h00, 8'h00};
    vecs[3] = '{8'hF0, 20, 8'hF0, 8'hF0, 8'h01};
    vecs[4] = '{8'h00, 20, 8'h00, 8'h00, 8'hF0};
    vecs[5] = '{8'h0F, 20, 8'h0F, 8'h0F, 8'h00};
    vecs[6] = '{8'h0A,  4, 8'h0F, 8'h00, 8'h00};
    vecs[7] = '{8'h0F, 20, 8'h0F, 8'h00, 8'h00};
    vecs[8] = '{8'h00, 20, 8'h00, 8'h00, 8'h0F};

    n_vec      = 0;
    n_err      = 0;
    chk_en     = 1'b1;
    rst_n      = 1'b0;
    bus.raw_in = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_level", bus.level_out, RV);
    check("reset_tick",  {7'd0, bus.tick_out}, 8'h00);
    rst_n = 1'b1;

    // first tick lands on clock TD-1 after release
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.tick_out) break;
    end
    check("first_tick_clock", 8'(n), 8'(TD - 1));

    repeat (100) @(negedge clk);
    check("idle_level", bus.level_out, 8'h00);

    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      bus.raw_in = vecs[v].raw;
      r_acc = '0;
      f_acc = '0;
      for (int c = 0; c < vecs[v].hold; c++) begin
        @(negedge clk);
        #2;
        r_acc |= bus.rise_out;
        f_acc |= bus.fall_out;
      end
      check($sformatf("vec%0d_level", v), bus.level_out, vecs[v].exp_level);
      check($sformatf("vec%0d_rise", v),  r_acc, vecs[v].exp_rise & EDGE_MASK);
      check($sformatf("vec%0d_fall", v),  f_acc, vecs[v].exp_fall & EDGE_MASK);
    end

    // reset after two of three qualifying ticks on bit 2
    @(negedge clk);
    bus.raw_in = 8'h04;
    n = 0;
    while (n < 40 && trailing(2) != 2) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("two_ticks_reached", 8'(trailing(2)), 8'd2);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("rst_level2", {7'd0, bus.level_out[2]}, 8'h00);
      check("rst_rise",   bus.rise_out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // sync reloads after 2 clocks; ticks evaluate on edges 4, 8, 12
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.level_out[2]) break;
    end
    check("fresh_flip_clocks", 8'(n), 8'd12);
    check("fresh_flip_rise",   bus.rise_out, 8'h04 & EDGE_MASK);

    @(negedge clk);
    bus.raw_in = 8'h00;
    repeat (20) @(negedge clk);

    // random stimulus, mostly slow changes with occasional short glitches
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rv = $urandom_range(0, 255);
        bus.raw_in = 8'(rv);
      end else if ($urandom_range(0, 7) == 0) begin
        rv = $urandom_range(0, 7);
        bus.raw_in = bus.raw_in ^ (8'h01 << rv);
      end
    end

    bus.raw_in = 8'h00;
    repeat (20) @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
